// File: rtl/if_id_if.sv
// if_id_if: fetch/stall-unit/flush side bundle for the IF/ID pipeline register
interface if_id_if;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;
  logic        if_valid;
  logic        if_pending;
  logic        id_ex_stall;
  logic        flush;
  logic        if_stall;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic        if_id_valid;
  logic [2:0]  if_id_Rs;
  logic [2:0]  if_id_Rt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] drop_cnt;
  modport master (
    output if_instr, if_pc_inc, if_valid, if_pending, id_ex_stall, flush,
    input  if_stall, if_id_instr, if_id_pc_inc, if_id_valid, if_id_Rs, if_id_Rt,
           stall_cnt, flush_cnt, drop_cnt
  );
  modport slave (
    input  if_instr, if_pc_inc, if_valid, if_pending, id_ex_stall, flush,
    output if_stall, if_id_instr, if_id_pc_inc, if_id_valid, if_id_Rs, if_id_Rt,
           stall_cnt, flush_cnt, drop_cnt
  );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall hold, flush bubbles and late-beat drop; IF_ID_PERF_EN enables perf counters
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic   clk,
  input logic   rst_n,
  if_id_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FULL, DROP} state_t;
  state_t      state, state_nxt;
  logic [15:0] instr, instr_nxt, pc, pc_nxt;
  logic        hold;
  assign hold             = bus.id_ex_stall & (state == FULL);
  assign bus.if_stall     = hold;
  assign bus.if_id_instr  = instr;
  assign bus.if_id_pc_inc = pc;
  assign bus.if_id_valid  = (state == FULL);
  assign bus.if_id_Rs     = instr[10:8];
  assign bus.if_id_Rt     = instr[7:5];
  // next state: flush beats hold beats load; a flush with a fetch in flight arms DROP
  always_comb begin
    state_nxt = state;
    instr_nxt = instr;
    pc_nxt    = pc;
    if (bus.flush) begin
      state_nxt = ((bus.if_pending & ~bus.if_valid) | (state == DROP)) ? DROP : EMPTY;
      instr_nxt = NOP_INSTR;
    end else if (state == DROP) begin
      state_nxt = bus.if_valid ? EMPTY : DROP;
    end else if (!hold) begin
      state_nxt = bus.if_valid ? FULL : EMPTY;
      instr_nxt = bus.if_valid ? bus.if_instr : NOP_INSTR;
      pc_nxt    = bus.if_valid ? bus.if_pc_inc : pc;
    end
  end
  // state and payload registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      instr <= NOP_INSTR;
      pc    <= 16'h0000;
    end else begin
      state <= state_nxt;
      instr <= instr_nxt;
      pc    <= pc_nxt;
    end
  end
`ifdef IF_ID_PERF_EN
  logic        drop_evt;
  logic [15:0] stall_q, flush_q, drop_q;
  assign drop_evt      = (state == DROP) & bus.if_valid & ~bus.flush;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  assign bus.drop_cnt  = drop_q;
  // saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
      drop_q  <= 16'h0000;
    end else begin
      stall_q <= (hold && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
      flush_q <= (bus.flush && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
      drop_q  <= (drop_evt && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
  end
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
  assign bus.drop_cnt  = 16'h0000;
`endif
endmodule
